// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage controller: one valid/yumi data-memory transaction per mem instruction
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    input  logic              is_mem_op_i,
    input  logic              is_load_op_i,
    input  logic              is_store_op_i,
    input  logic              is_byte_op_i,
    input  logic [4:0]        rd_addr_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              dmem_v_o,
    output logic              dmem_w_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    output logic [3:0]        dmem_mask_o,
    input  logic              dmem_yumi_i,
    input  logic              dmem_rdata_v_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic              wb_v_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              misalign_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state, state_n;
    logic       load_q;
    logic       byte_q;
    logic [1:0] lane_q;
    logic [4:0] rd_q;
    logic       is_mem;
    logic       misaligned;
    logic       capture;
    logic       rsp_take;

    // Any mem op that is not a load is treated as a store, so the store flag is informational.
    logic       unused_store_flag;
    assign unused_store_flag = is_store_op_i;

    assign is_mem     = valid_i & is_mem_op_i;
    assign misaligned = ~is_byte_op_i & (addr_i[1:0] != 2'b00);
    assign capture    = (state == IDLE) & is_mem & ~misaligned;
    assign rsp_take   = dmem_rdata_v_i & ((state == WAIT) | ((state == REQ) & dmem_yumi_i & load_q));

    always_comb begin
        state_n  = state;
        dmem_v_o = 1'b0;
        stall_o  = 1'b0;
        wb_v_o   = 1'b0;
        case (state)
            IDLE: begin
                stall_o = is_mem & ~misaligned;
                if (capture) state_n = REQ;
            end
            REQ: begin
                dmem_v_o = 1'b1;
                stall_o  = 1'b1;
                if (dmem_yumi_i) begin
                    if (!load_q || dmem_rdata_v_i) state_n = DONE;
                    else                           state_n = WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (dmem_rdata_v_i) state_n = DONE;
            end
            DONE: begin
                wb_v_o  = load_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            load_q       <= 1'b0;
            byte_q       <= 1'b0;
            lane_q       <= 2'b00;
            rd_q         <= 5'd0;
            dmem_w_o     <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_mask_o  <= 4'h0;
            wb_rd_o      <= 5'd0;
            wb_data_o    <= '0;
            misalign_o   <= 1'b0;
        end else begin
            state      <= state_n;
            misalign_o <= (state == IDLE) & is_mem & misaligned;
            if (capture) begin
                load_q       <= is_load_op_i;
                byte_q       <= is_byte_op_i;
                lane_q       <= addr_i[1:0];
                rd_q         <= rd_addr_i;
                dmem_w_o     <= ~is_load_op_i;
                dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                dmem_wdata_o <= is_byte_op_i ? {4{store_data_i[7:0]}} : store_data_i;
                if (is_load_op_i)      dmem_mask_o <= 4'h0;
                else if (is_byte_op_i) dmem_mask_o <= 4'b0001 << addr_i[1:0];
                else                   dmem_mask_o <= 4'hF;
            end
            if (rsp_take) begin
                wb_rd_o   <= rd_q;
                wb_data_o <= byte_q ? {{(DATA_W-8){1'b0}}, dmem_rdata_i[{lane_q, 3'b000} +: 8]}
                                    : dmem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed plus randomized checks of mem_access_unit against an arithmetic model
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_i, is_mem_op_i, is_load_op_i, is_store_op_i, is_byte_op_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] addr_i, store_data_i;
    logic        dmem_v_o, dmem_w_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_mask_o;
    logic        dmem_yumi_i, dmem_rdata_v_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, wb_v_o, misalign_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int total = 0;
    int fails = 0;

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .is_mem_op_i(is_mem_op_i),
        .is_load_op_i(is_load_op_i), .is_store_op_i(is_store_op_i), .is_byte_op_i(is_byte_op_i),
        .rd_addr_i(rd_addr_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_mask_o(dmem_mask_o), .dmem_yumi_i(dmem_yumi_i),
        .dmem_rdata_v_i(dmem_rdata_v_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
        .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_v"}, dmem_v_o, 0);
        chk({tag, "_w"}, dmem_w_o, 0);
        chk({tag, "_addr"}, dmem_addr_o, 0);
        chk({tag, "_wdata"}, dmem_wdata_o, 0);
        chk({tag, "_mask"}, dmem_mask_o, 0);
        chk({tag, "_stall"}, stall_o, 0);
        chk({tag, "_wbv"}, wb_v_o, 0);
        chk({tag, "_wbrd"}, wb_rd_o, 0);
        chk({tag, "_wbdata"}, wb_data_o, 0);
        chk({tag, "_mis"}, misalign_o, 0);
    endtask

    task automatic idle_inputs();
        valid_i = 0; is_mem_op_i = 0; is_load_op_i = 0; is_store_op_i = 0; is_byte_op_i = 0;
        rd_addr_i = 0; addr_i = 0; store_data_i = 0;
        dmem_yumi_i = 0; dmem_rdata_v_i = 0; dmem_rdata_i = 0;
    endtask

    // One full aligned transaction. yd = REQ cycles without yumi; wd = WAIT cycles until response
    // (0 means the response arrives together with yumi).
    task automatic txn(input bit ld, input bit by, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] sd, input int yd, input int wd, input logic [31:0] rdata);
        logic [31:0] e_addr, e_wdata, e_wb;
        logic [3:0]  e_mask;
        int          lane;
        lane    = a % 4;
        e_addr  = a - lane;
        e_wdata = by ? (sd % 256) * 32'h0101_0101 : sd;
        e_mask  = ld ? 4'd0 : (by ? 4'(1 << lane) : 4'd15);
        e_wb    = by ? (rdata >> (8 * lane)) % 256 : rdata;

        @(negedge clk);
        valid_i = 1; is_mem_op_i = 1; is_load_op_i = ld; is_store_op_i = !ld; is_byte_op_i = by;
        rd_addr_i = rd; addr_i = a; store_data_i = sd;
        #1 chk("cap_stall", stall_o, 1);
        chk("cap_v", dmem_v_o, 0);
        for (int i = 0; i <= yd; i++) begin
            @(negedge clk);
            #1 chk("req_v", dmem_v_o, 1);
            chk("req_stall", stall_o, 1);
            chk("req_addr", dmem_addr_o, e_addr);
            chk("req_w", dmem_w_o, !ld);
            chk("req_mask", dmem_mask_o, e_mask);
            if (!ld) chk("req_wdata", dmem_wdata_o, e_wdata);
            dmem_yumi_i    = (i == yd);
            dmem_rdata_v_i = ld && (i == yd) && (wd == 0);
            dmem_rdata_i   = dmem_rdata_v_i ? rdata : $urandom;
        end
        if (ld && wd > 0) begin
            for (int j = 0; j < wd; j++) begin
                @(negedge clk);
                dmem_yumi_i = $urandom_range(0, 1);
                #1 chk("wait_v", dmem_v_o, 0);
                chk("wait_stall", stall_o, 1);
                dmem_rdata_v_i = (j == wd - 1);
                dmem_rdata_i   = dmem_rdata_v_i ? rdata : $urandom;
            end
        end
        @(negedge clk);
        dmem_yumi_i = 0; dmem_rdata_v_i = 1; dmem_rdata_i = $urandom;
        #1 chk("done_stall", stall_o, 0);
        chk("done_v", dmem_v_o, 0);
        chk("done_wbv", wb_v_o, ld);
        if (ld) begin
            chk("done_wbdata", wb_data_o, e_wb);
            chk("done_wbrd", wb_rd_o, rd);
        end
        @(negedge clk);
        valid_i = 0; dmem_rdata_v_i = 0;
        #1 chk("after_wbv", wb_v_o, 0);
        chk("after_stall", stall_o, 0);
        chk("after_v", dmem_v_o, 0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk);
        #1 chk_all_zero("reset");
        reset_n = 1;

        // Stray yumi/response while idle must be ignored.
        @(negedge clk);
        dmem_yumi_i = 1; dmem_rdata_v_i = 1; dmem_rdata_i = 32'h1234_5678;
        @(negedge clk);
        dmem_yumi_i = 0; dmem_rdata_v_i = 0;
        #1 chk("idle_ign_v", dmem_v_o, 0);
        chk("idle_ign_wbv", wb_v_o, 0);
        chk("idle_ign_stall", stall_o, 0);

        txn(0, 0, 5'd0, 32'h104, 32'hDEAD_BEEF, 0, 0, 32'h0);
        txn(1, 1, 5'd7, 32'h203, 32'h0, 2, 3, 32'hAABB_CCDD);
        txn(0, 1, 5'd0, 32'h11, 32'h1234_56F0, 0, 0, 32'h0);
        txn(1, 0, 5'd9, 32'h40, 32'h0, 0, 0, 32'h0000_0042);

        // Misaligned word load: no request, single-cycle misalign pulse.
        @(negedge clk);
        valid_i = 1; is_mem_op_i = 1; is_load_op_i = 1; is_store_op_i = 0; is_byte_op_i = 0;
        addr_i = 32'h06;
        #1 chk("mis_stall", stall_o, 0);
        chk("mis_v0", dmem_v_o, 0);
        @(negedge clk);
        valid_i = 0;
        #1 chk("mis_pulse", misalign_o, 1);
        chk("mis_v1", dmem_v_o, 0);
        @(negedge clk);
        #1 chk("mis_end", misalign_o, 0);
        chk("mis_v2", dmem_v_o, 0);

        // Reset during WAIT abandons the load.
        @(negedge clk);
        valid_i = 1; is_mem_op_i = 1; is_load_op_i = 1; is_store_op_i = 0; is_byte_op_i = 0;
        rd_addr_i = 5'd3; addr_i = 32'h80;
        @(negedge clk);
        dmem_yumi_i = 1;
        @(negedge clk);
        dmem_yumi_i = 0;
        #1 chk("rst_wait_stall", stall_o, 1);
        reset_n = 0; valid_i = 0;
        @(negedge clk);
        reset_n = 1;
        #1 chk_all_zero("midrst");
        dmem_rdata_v_i = 1; dmem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rdata_v_i = 0;
        #1 chk("midrst_wbv", wb_v_o, 0);
        chk("midrst_stall", stall_o, 0);
        chk("midrst_v", dmem_v_o, 0);
        chk("midrst_wbdata", wb_data_o, 0);

        for (int n = 0; n < 24; n++) begin
            bit          ld, by;
            logic [31:0] a;
            ld = $urandom_range(0, 1);
            by = $urandom_range(0, 1);
            a  = $urandom;
            if (!by) a[1:0] = 2'b00;
            txn(ld, by, 5'($urandom), a, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
